// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and address constants.
package fetch_pkg;

    localparam int unsigned WORD_AW = 30;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: completed fetches and IMEM stall cycles.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  fetch_state_e state_i,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    output logic [31:0]  fetch_cnt_o,
    output logic [31:0]  wait_cnt_o
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] wait_cnt_q,  wait_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (state_i == ST_WAIT && imem_rvalid_i) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        // Stall: request not yet accepted, or response not yet returned.
        if ((state_i == ST_REQ && !imem_gnt_i) || (state_i == ST_WAIT && !imem_rvalid_i)) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign wait_cnt_o  = wait_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: architectural PC, req/gnt/rvalid IMEM fetch, instruction register.
// Optional perf counters (fetch_cnt_o, wait_cnt_o) enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:2] npc_i,
    input  logic        pc_we_i,
    output logic [31:2] pc_o,
    output logic        imem_req_o,
    output logic [31:2] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] wait_cnt_o,
`endif
    output logic [31:0] ir_o,
    output logic        ir_valid_o
);

    fetch_state_e        state_q;
    logic [WORD_AW-1:0]  pc_q;
    logic [31:0]         ir_q;
    logic                ir_valid_q;

    // Commits outside HOLD and responses outside WAIT fall through the case untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RST;
            pc_q       <= RESET_PC[31:2];
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RST: state_q <= ST_REQ;
                ST_REQ: begin
                    if (imem_gnt_i) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        ir_q       <= imem_rdata_i;
                        ir_valid_q <= 1'b1;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (pc_we_i) begin
                        pc_q       <= npc_i;
                        ir_valid_q <= 1'b0;
                        state_q    <= ST_REQ;
                    end
                end
                default: state_q <= ST_RST;
            endcase
        end
    end

    assign pc_o        = pc_q;
    assign imem_req_o  = (state_q == ST_REQ);
    assign imem_addr_o = pc_q;
    assign ir_o        = ir_q;
    assign ir_valid_o  = ir_valid_q;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt u_perf_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .state_i       (state_q),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .fetch_cnt_o   (fetch_cnt_o),
        .wait_cnt_o    (wait_cnt_o)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; covers perf counters when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:2] npc_i;
    logic        pc_we_i;
    logic [31:2] pc_o;
    logic        imem_req_o;
    logic [31:2] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] ir_o;
    logic        ir_valid_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] wait_cnt_o;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .npc_i         (npc_i),
        .pc_we_i       (pc_we_i),
        .pc_o          (pc_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt_o   (fetch_cnt_o),
        .wait_cnt_o    (wait_cnt_o),
`endif
        .ir_o          (ir_o),
        .ir_valid_o    (ir_valid_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch_out(input string tag, input logic req, input logic [31:2] pc,
                                 input logic vld, input logic [31:0] ir);
        check({tag, ".req"},  {31'd0, imem_req_o}, {31'd0, req});
        check({tag, ".pc"},   {2'b00, pc_o},        {2'b00, pc});
        check({tag, ".addr"}, {2'b00, imem_addr_o}, {2'b00, pc});
        check({tag, ".vld"},  {31'd0, ir_valid_o},  {31'd0, vld});
        check({tag, ".ir"},   ir_o,                 ir);
    endtask

    initial begin
        rst_n = 1'b0; npc_i = '0; pc_we_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        step(); step();
        chk_fetch_out("reset", 1'b0, 30'h0C00, 1'b0, 32'h0);

        // Zero-wait fetch of the reset PC
        rst_n = 1'b1;
        step();
        chk_fetch_out("rel", 1'b1, 30'h0C00, 1'b0, 32'h0);
        imem_gnt_i = 1'b1;
        step();
        chk_fetch_out("wait0", 1'b0, 30'h0C00, 1'b0, 32'h0);
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3402_0005;
        step();
        imem_rvalid_i = 1'b0;
        chk_fetch_out("hold0", 1'b0, 30'h0C00, 1'b1, 32'h3402_0005);

        // Sequential commit
        npc_i = 30'h0C01; pc_we_i = 1'b1;
        step();
        pc_we_i = 1'b0;
        chk_fetch_out("commit", 1'b1, 30'h0C01, 1'b0, 32'h3402_0005);

        // Grant withheld 3 cycles (4 REQ cycles total); pc_we in REQ ignored
        npc_i = 30'h1234; pc_we_i = 1'b1;
        step();
        pc_we_i = 1'b0;
        chk_fetch_out("req2", 1'b1, 30'h0C01, 1'b0, 32'h3402_0005);
        step();
        chk_fetch_out("req3", 1'b1, 30'h0C01, 1'b0, 32'h3402_0005);
        step();
        chk_fetch_out("req4", 1'b1, 30'h0C01, 1'b0, 32'h3402_0005);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        chk_fetch_out("wait1", 1'b0, 30'h0C01, 1'b0, 32'h3402_0005);

        // rvalid delayed: 3 stalled WAIT cycles; pc_we in WAIT ignored
        npc_i = 30'h1234; pc_we_i = 1'b1;
        step();
        pc_we_i = 1'b0;
        chk_fetch_out("wait2", 1'b0, 30'h0C01, 1'b0, 32'h3402_0005);
        step();
        chk_fetch_out("wait3", 1'b0, 30'h0C01, 1'b0, 32'h3402_0005);
        step();
        chk_fetch_out("wait4", 1'b0, 30'h0C01, 1'b0, 32'h3402_0005);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h8C22_0004;
        step();
        imem_rvalid_i = 1'b0;
        chk_fetch_out("hold1", 1'b0, 30'h0C01, 1'b1, 32'h8C22_0004);
`ifdef FETCH_PERF_CNT_EN
        // Two fetches so far; stalls only in the second (3 REQ + 3 WAIT)
        check("perf.fetch1", fetch_cnt_o, 32'd2);
        check("perf.wait1",  wait_cnt_o,  32'd6);
`endif

        // Spurious rvalid and gnt in HOLD ignored
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; imem_gnt_i = 1'b1;
        step();
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0;
        chk_fetch_out("spur", 1'b0, 30'h0C01, 1'b1, 32'h8C22_0004);

        // Jump to top of address space, no truncation
        npc_i = 30'h3FFF_FFFF; pc_we_i = 1'b1;
        step();
        pc_we_i = 1'b0;
        chk_fetch_out("jump", 1'b1, 30'h3FFF_FFFF, 1'b0, 32'h8C22_0004);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0800_0C00;
        step();
        imem_rvalid_i = 1'b0;
        chk_fetch_out("jhold", 1'b0, 30'h3FFF_FFFF, 1'b1, 32'h0800_0C00);

        // Reset during WAIT, stale response delivered after release
        npc_i = 30'h0C05; pc_we_i = 1'b1;
        step();
        pc_we_i = 1'b0; imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        chk_fetch_out("rwait", 1'b0, 30'h0C05, 1'b0, 32'h0800_0C00);
        rst_n = 1'b0;
        step();
        chk_fetch_out("rst1", 1'b0, 30'h0C00, 1'b0, 32'h0);
        step();
        chk_fetch_out("rst2", 1'b0, 30'h0C00, 1'b0, 32'h0);
        rst_n = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0001;
        step();
        chk_fetch_out("stale1", 1'b1, 30'h0C00, 1'b0, 32'h0);
        step();
        chk_fetch_out("stale2", 1'b1, 30'h0C00, 1'b0, 32'h0);
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3402_0005;
        step();
        imem_rvalid_i = 1'b0;
        chk_fetch_out("refetch", 1'b0, 30'h0C00, 1'b1, 32'h3402_0005);
`ifdef FETCH_PERF_CNT_EN
        // After reset: one fetch, one stalled REQ cycle (the stale-rvalid cycle)
        check("perf.fetch2", fetch_cnt_o, 32'd1);
        check("perf.wait2",  wait_cnt_o,  32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
